// File: rtl/sq_mag_energy_detector.sv
// Frame energy detector: sums N square-magnitude samples per frame, then holds
// the total and a threshold flag until downstream accepts it.
module sq_mag_energy_detector #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned FFT_LEN_LOG2 = 8,
  parameter int unsigned ACC_W        = DATA_W + FFT_LEN_LOG2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_mag,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  input  logic [ACC_W-1:0]  threshold,
  output logic [ACC_W-1:0]  out_energy,
  output logic              out_detect,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_err
);

  typedef enum logic [0:0] {StAccum, StHold} state_e;

  state_e                  state_q, state_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [FFT_LEN_LOG2-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0]        energy_q, energy_d;
  logic                    detect_q, detect_d;
  logic                    err_q, err_d;

  logic [ACC_W-1:0] sum;
  logic             last_bin;

  assign sum      = acc_q + ACC_W'(s_mag);
  assign last_bin = (cnt_q == {FFT_LEN_LOG2{1'b1}});

  // Handshake flags depend on state only, so there is no path from s_* to out_*.
  assign s_ready    = (state_q == StAccum);
  assign out_valid  = (state_q == StHold);
  assign out_energy = energy_q;
  assign out_detect = detect_q;
  assign frame_err  = err_q;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    energy_d = energy_q;
    detect_d = detect_q;
    err_d    = 1'b0;

    unique case (state_q)
      StAccum: begin
        if (s_valid) begin
          if (s_last && last_bin) begin
            energy_d = sum;
            detect_d = (sum > threshold);
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = StHold;
          end else if (s_last || last_bin) begin
            // Early or missing last: drop the partial frame and resync.
            err_d = 1'b1;
            acc_d = '0;
            cnt_d = '0;
          end else begin
            acc_d = sum;
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StHold: begin
        if (out_ready) begin
          state_d = StAccum;
        end
      end
      default: state_d = StAccum;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StAccum;
      acc_q    <= '0;
      cnt_q    <= '0;
      energy_q <= '0;
      detect_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      energy_q <= energy_d;
      detect_q <= detect_d;
      err_q    <= err_d;
    end
  end

endmodule
